ddr_term_ctrl: RTL

Sequences one Spartan-6 MCB user port (pX_*) on behalf of the FX3 device-interface (di_*) host transfers so the PC can block-read and block-write DDR2 through a dedicated terminal. It runs beside the register terminals in the project top level. When the terminal is selected, the top-level mux routes its di_* outputs. Writes are packed into MCB write-FIFO bursts; reads are prefetched in bursts and streamed from the MCB read FIFO.

---
 rtl/ddr_term_ctrl.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/ddr_term_ctrl.sv
// ddr_term_ctrl: bridges FX3 device-interface block transfers onto one
// Spartan-6 MCB user port. Writes are packed into write-FIFO bursts and
// read data is prefetched in bursts, then streamed out of the MCB read FIFO.
module ddr_term_ctrl #(
   parameter logic [15:0] TERM_ADDR = 16'h0040,
   parameter int          BURST_LEN = 32
) (
   input  logic        ifclk,
   input  logic        reset,
   input  logic [15:0] di_term_addr,
   input  logic [31:0] di_reg_addr,
   input  logic [31:0] di_len,
   input  logic        di_read_mode,
   input  logic        di_read,
   input  logic        di_write_mode,
   input  logic        di_write,
   input  logic [31:0] di_reg_datai,
   output logic        di_read_rdy,
   output logic [31:0] di_reg_datao,
   output logic        di_write_rdy,
   output logic [15:0] di_transfer_status,
   output logic        mcb_cmd_en,
   output logic [2:0]  mcb_cmd_instr,
   output logic [5:0]  mcb_cmd_bl,
   output logic [29:0] mcb_cmd_byte_addr,
   input  logic        mcb_cmd_full,
   output logic        mcb_wr_en,
   output logic [3:0]  mcb_wr_mask,
   output logic [31:0] mcb_wr_data,
   input  logic        mcb_wr_full,
   input  logic        mcb_wr_underrun,
   input  logic        mcb_wr_error,
   output logic        mcb_rd_en,
   input  logic [31:0] mcb_rd_data,
   input  logic        mcb_rd_empty,
   input  logic        mcb_rd_overflow,
   input  logic        mcb_rd_error
);

   localparam logic [5:0] BURST     = 6'(BURST_LEN);
   localparam logic [7:0] OUTST_MAX = 8'd64;

   typedef enum logic [2:0] {
      IDLE,
      WR_FILL,
      WR_CMD,
      RD_RUN,
      RD_FLUSH,
      DONE
   } state_t;

   state_t      state, state_n;
   logic [29:0] addr, addr_n;
   logic [29:0] words, words_n;
   logic [29:0] req, req_n;
   logic [5:0]  fill, fill_n;
   logic [6:0]  outst, outst_n;
   logic [5:0]  status, status_n;
   logic        wr_mode_q, rd_mode_q;

   logic        sel;
   logic        wr_rise, rd_rise;
   logic [5:0]  burst_n;
   logic        issue;
   logic        pop;
   logic        unused_bits;

   assign unused_bits = &{1'b0, di_reg_addr[31:30], di_reg_addr[1:0]};

   assign sel     = (di_term_addr == TERM_ADDR);
   assign wr_rise = di_write_mode & ~wr_mode_q;
   assign rd_rise = di_read_mode & ~rd_mode_q;

   // Read command sizing: next burst is the smaller of the remaining request and
   // the burst limit, and it may only go out if the read FIFO can absorb it.
   always_comb begin
      burst_n = (req < {24'd0, BURST}) ? req[5:0] : BURST;
      issue   = (state == RD_RUN) && (req != 30'd0) && !mcb_cmd_full &&
                (({1'b0, outst} + {2'b00, burst_n}) <= OUTST_MAX);
   end

   // Next-state, datapath updates and all port outputs; outputs are forced
   // quiet while reset is held so nothing reaches the MCB mid-reset.
   always_comb begin
      state_n           = state;
      addr_n            = addr;
      words_n           = words;
      req_n             = req;
      fill_n            = fill;
      outst_n           = outst;
      status_n          = status | {2'b00, mcb_rd_error, mcb_rd_overflow,
                                    mcb_wr_error, mcb_wr_underrun};
      pop               = 1'b0;
      di_read_rdy       = 1'b0;
      di_reg_datao      = 32'd0;
      di_write_rdy      = 1'b0;
      mcb_cmd_en        = 1'b0;
      mcb_cmd_instr     = 3'b000;
      mcb_cmd_bl        = 6'd0;
      mcb_cmd_byte_addr = 30'd0;
      mcb_wr_en         = 1'b0;
      mcb_wr_data       = 32'd0;
      mcb_rd_en         = 1'b0;

      case (state)
         IDLE: begin
            if (sel && (wr_rise || rd_rise)) begin
               addr_n   = {di_reg_addr[29:2], 2'b00};
               words_n  = di_len[31:2];
               req_n    = di_len[31:2];
               fill_n   = 6'd0;
               outst_n  = 7'd0;
               status_n = 6'd0;
               if ((di_len[1:0] != 2'b00) || (di_len[31:2] == 30'd0)) begin
                  status_n[4] = 1'b1;
                  state_n     = DONE;
               end else if (wr_rise) begin
                  state_n = WR_FILL;
               end else begin
                  state_n = RD_RUN;
               end
            end
         end

         WR_FILL: begin
            di_write_rdy = sel && !mcb_wr_full && (fill < BURST);
            if (di_write && di_write_rdy) begin
               mcb_wr_en   = 1'b1;
               mcb_wr_data = di_reg_datai;
               fill_n      = fill + 6'd1;
               words_n     = words - 30'd1;
            end
            if ((fill_n == BURST) || (words_n == 30'd0)) begin
               state_n = WR_CMD;
            end else if (!di_write_mode) begin
               status_n[5] = 1'b1;
               state_n     = (fill_n != 6'd0) ? WR_CMD : DONE;
            end
         end

         WR_CMD: begin
            if (!mcb_cmd_full) begin
               mcb_cmd_en        = 1'b1;
               mcb_cmd_instr     = 3'b000;
               mcb_cmd_bl        = fill - 6'd1;
               mcb_cmd_byte_addr = addr;
               addr_n            = addr + {22'd0, fill, 2'b00};
               fill_n            = 6'd0;
               if ((words != 30'd0) && di_write_mode) begin
                  state_n = WR_FILL;
               end else begin
                  if (words != 30'd0) status_n[5] = 1'b1;
                  state_n = DONE;
               end
            end
         end

         RD_RUN: begin
            di_read_rdy  = sel && !mcb_rd_empty;
            di_reg_datao = sel ? mcb_rd_data : 32'd0;
            pop          = di_read && di_read_rdy;
            mcb_rd_en    = pop;
            if (issue) begin
               mcb_cmd_en        = 1'b1;
               mcb_cmd_instr     = 3'b001;
               mcb_cmd_bl        = burst_n - 6'd1;
               mcb_cmd_byte_addr = addr;
               addr_n            = addr + {22'd0, burst_n, 2'b00};
               req_n             = req - {24'd0, burst_n};
            end
            outst_n = outst + (issue ? {1'b0, burst_n} : 7'd0) - (pop ? 7'd1 : 7'd0);
            if (pop) words_n = words - 30'd1;
            if (words_n == 30'd0) begin
               state_n = DONE;
            end else if (!di_read_mode) begin
               status_n[5] = 1'b1;
               state_n     = (outst_n != 7'd0) ? RD_FLUSH : DONE;
            end
         end

         RD_FLUSH: begin
            mcb_rd_en = !mcb_rd_empty;
            if (!mcb_rd_empty && (outst != 7'd0)) outst_n = outst - 7'd1;
            if (outst_n == 7'd0) state_n = DONE;
         end

         DONE: begin
            if (!di_write_mode && !di_read_mode) state_n = IDLE;
         end

         default: state_n = IDLE;
      endcase

      if (reset) begin
         di_read_rdy       = 1'b0;
         di_reg_datao      = 32'd0;
         di_write_rdy      = 1'b0;
         mcb_cmd_en        = 1'b0;
         mcb_cmd_instr     = 3'b000;
         mcb_cmd_bl        = 6'd0;
         mcb_cmd_byte_addr = 30'd0;
         mcb_wr_en         = 1'b0;
         mcb_wr_data       = 32'd0;
         mcb_rd_en         = 1'b0;
      end
   end

   // State and datapath registers with synchronous reset; mode bits are
   // delayed one cycle so IDLE can see their rising edges.
   always_ff @(posedge ifclk) begin
      if (reset) begin
         state     <= IDLE;
         addr      <= 30'd0;
         words     <= 30'd0;
         req       <= 30'd0;
         fill      <= 6'd0;
         outst     <= 7'd0;
         status    <= 6'd0;
         wr_mode_q <= 1'b0;
         rd_mode_q <= 1'b0;
      end else begin
         state     <= state_n;
         addr      <= addr_n;
         words     <= words_n;
         req       <= req_n;
         fill      <= fill_n;
         outst     <= outst_n;
         status    <= status_n;
         wr_mode_q <= di_write_mode;
         rd_mode_q <= di_read_mode;
      end
   end

   assign di_transfer_status = {10'd0, status};
   assign mcb_wr_mask        = 4'd0;

endmodule
